// File: rtl/seq_alu_pkg.sv
// Shared op and FSM-state encodings for the sequential ALU and its mul/div datapath.
// ADD/SUB/OR keep the legacy single-cycle ALU codes, widened to three bits.
package seq_alu_pkg;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_OR   = 3'b010;
    localparam logic [2:0] OP_AND  = 3'b011;
    localparam logic [2:0] OP_XOR  = 3'b100;
    localparam logic [2:0] OP_SLT  = 3'b101;
    localparam logic [2:0] OP_MULU = 3'b110;
    localparam logic [2:0] OP_DIVU = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/seq_alu_muldiv.sv
// Iterative unsigned shift-add multiplier / restoring divider, one bit per cycle.
// Latency WIDTH cycles after start; lo/hi/done reflect the state about to be registered.
module seq_alu_muldiv
    import seq_alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [2:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] lo_o,
    output logic [WIDTH-1:0] hi_o,
    output logic             done_o
);

    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   m_q, m_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               is_mul_q, is_mul_d;
    logic [WIDTH:0]     add_s;
    logic [WIDTH:0]     trial;

    // Multiply: acc = {partial, multiplier}, m = multiplicand.
    // Divide:   acc = {remainder, dividend/quotient}, m = divisor.
    always_comb begin
        acc_d    = acc_q;
        m_d      = m_q;
        cnt_d    = cnt_q;
        is_mul_d = is_mul_q;
        add_s    = '0;
        trial    = '0;
        if (start_i) begin
            is_mul_d = (op_i == OP_MULU);
            m_d      = is_mul_d ? a_i : b_i;
            acc_d    = {{WIDTH{1'b0}}, (is_mul_d ? b_i : a_i)};
            cnt_d    = CNT_W'(WIDTH);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
            if (is_mul_q) begin
                add_s = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, m_q} : '0);
                acc_d = {add_s, acc_q[WIDTH-1:1]};
            end else begin
                trial = acc_q[2*WIDTH-1:WIDTH-1] - {1'b0, m_q};
                if (!trial[WIDTH]) begin
                    acc_d = {trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
                end else begin
                    acc_d = {acc_q[2*WIDTH-2:0], 1'b0};
                end
            end
        end
    end

    assign done_o = (cnt_q == CNT_W'(1));
    assign lo_o   = acc_d[WIDTH-1:0];
    assign hi_o   = acc_d[2*WIDTH-1:WIDTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q    <= '0;
            m_q      <= '0;
            cnt_q    <= '0;
            is_mul_q <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            m_q      <= m_d;
            cnt_q    <= cnt_d;
            is_mul_q <= is_mul_d;
        end
    end

endmodule

// File: rtl/seq_alu.sv
// Multi-cycle ALU: single-cycle ADD..SLT, iterative MULU/DIVU, valid/ready on both sides.
// Latency 1 (single-cycle ops, DIVU by zero) or WIDTH+1; result held in DONE until out_ready.
module seq_alu
    import seq_alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       alu_op,
    input  logic [WIDTH-1:0] alu_da,
    input  logic [WIDTH-1:0] alu_db,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] alu_dc,
    output logic [WIDTH-1:0] alu_hi,
    output logic             alu_zero,
    output logic             alu_ovf
);

    state_t           state_q;
    logic [2:0]       op_q;
    logic [WIDTH-1:0] dc_q, hi_q;
    logic             zero_q, ovf_q;

    logic [WIDTH-1:0] sum, diff, sc_dc, sc_hi;
    logic             sc_ovf;
    logic             accept, is_iter, md_start, md_done;
    logic [WIDTH-1:0] md_lo, md_hi;

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign accept    = in_valid & in_ready;
    assign is_iter   = (alu_op == OP_MULU) || ((alu_op == OP_DIVU) && (alu_db != '0));
    assign md_start  = accept & is_iter;

    assign alu_dc   = dc_q;
    assign alu_hi   = hi_q;
    assign alu_zero = zero_q;
    assign alu_ovf  = ovf_q;

    // Results for everything that finishes straight from IDLE, including divide-by-zero.
    always_comb begin
        sum    = alu_da + alu_db;
        diff   = alu_da + ~alu_db + WIDTH'(1);
        sc_dc  = '0;
        sc_hi  = '0;
        sc_ovf = 1'b0;
        case (alu_op)
            OP_ADD: begin
                sc_dc  = sum;
                sc_ovf = (alu_da[WIDTH-1] == alu_db[WIDTH-1]) && (sum[WIDTH-1] != alu_da[WIDTH-1]);
            end
            OP_SUB: begin
                sc_dc  = diff;
                sc_ovf = (alu_da[WIDTH-1] != alu_db[WIDTH-1]) && (diff[WIDTH-1] != alu_da[WIDTH-1]);
            end
            OP_OR:  sc_dc = alu_da | alu_db;
            OP_AND: sc_dc = alu_da & alu_db;
            OP_XOR: sc_dc = alu_da ^ alu_db;
            OP_SLT: sc_dc = {{(WIDTH-1){1'b0}}, ($signed(alu_da) < $signed(alu_db))};
            OP_DIVU: begin
                sc_dc  = '1;
                sc_hi  = alu_da;
                sc_ovf = 1'b1;
            end
            default: ;
        endcase
    end

    seq_alu_muldiv #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_muldiv (
        .clk     (clk),
        .rst     (rst),
        .start_i (md_start),
        .op_i    (alu_op),
        .a_i     (alu_da),
        .b_i     (alu_db),
        .lo_o    (md_lo),
        .hi_o    (md_hi),
        .done_o  (md_done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            op_q    <= OP_ADD;
            dc_q    <= '0;
            hi_q    <= '0;
            zero_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        op_q <= alu_op;
                        if (is_iter) begin
                            state_q <= ST_BUSY;
                        end else begin
                            state_q <= ST_DONE;
                            dc_q    <= sc_dc;
                            hi_q    <= sc_hi;
                            zero_q  <= (sc_dc == '0);
                            ovf_q   <= sc_ovf;
                        end
                    end
                end
                ST_BUSY: begin
                    if (md_done) begin
                        state_q <= ST_DONE;
                        dc_q    <= md_lo;
                        hi_q    <= md_hi;
                        zero_q  <= (md_lo == '0);
                        ovf_q   <= (op_q == OP_MULU) && (md_hi != '0);
                    end
                end
                ST_DONE: begin
                    if (out_ready) state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
- Parametrised, multi-cycle successor to the single-cycle ALU.
- Adds AND/XOR/SLT single-cycle ops, plus an iterative unsigned multiply and an iterative unsigned divide.
- Uses valid/ready handshakes on both the operand side and the result side.
- Sits between the register-read stage and write-back; the control unit stalls on in_ready/out_valid.

Parameters:
- WIDTH, 32, operand/result width in bits; must be ≥ 4.
- CNT_W, $clog2(WIDTH+1), width of the iteration counter (derived; do not override).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operands and op are valid this cycle.
- in_ready  out  1  block can accept a new operation.
- alu_op  in  3  000 ADD, 001 SUB, 010 OR, 011 AND, 100 XOR, 101 SLT, 110 MULU, 111 DIVU.
- alu_da  in  WIDTH  operand A (dividend for DIVU).
- alu_db  in  WIDTH  operand B (divisor for DIVU).
- out_valid  out  1  result fields valid.
- out_ready  in  1  consumer takes the result this cycle.
- alu_dc  out  WIDTH  primary result; low half for MULU, quotient for DIVU.
- alu_hi  out  WIDTH  high half for MULU, remainder for DIVU, 0 for all other ops.
- alu_zero  out  1  alu_dc == 0.
- alu_ovf  out  1  signed overflow (ADD/SUB), alu_hi != 0 (MULU), divisor == 0 (DIVU), else 0.

Behaviour:
- Clock/reset: one clock; synchronous active-high reset. rst has priority over every other event, including an accept in the same cycle.
- Reset state: FSM = IDLE; out_valid = 0; alu_dc, alu_hi, alu_zero, alu_ovf = 0; counter = 0.
- States: IDLE, BUSY, DONE. in_ready = (state == IDLE) only; no accept while BUSY or DONE.
- Accept: a transfer happens when in_valid & in_ready. Operands and op are captured into internal registers; inputs are don't-care afterwards.
- Single-cycle ops (ADD..SLT): IDLE→DONE. out_valid is high the cycle after accept (latency 1).
- ADD/SUB: WIDTH-bit two's complement; SUB = A + ~B + 1. Overflow for ADD is A, B same sign and result sign differs. Overflow for SUB is A, B different sign and result sign differs from A.
- SLT: signed compare; alu_dc = {WIDTH-1 zeros, A<B}.
- MULU: shift-add, one partial product per cycle. Accumulator is 2·WIDTH bits. IDLE→BUSY, stays BUSY for exactly WIDTH cycles, then DONE. out_valid rises WIDTH+1 cycles after accept.
- DIVU: restoring division, one quotient bit per cycle, same timing as MULU.
  - Divisor == 0: no iteration. IDLE→DONE with latency 1; alu_dc = all ones, alu_hi = dividend, alu_ovf = 1.
- DONE: result registers are held stable while out_ready = 0, for an unlimited number of cycles. When out_valid & out_ready: DONE→IDLE, out_valid = 0 next cycle, in_ready = 1 next cycle.
- Result registers are not cleared on leaving DONE; only out_valid qualifies them.
- Reset mid-BUSY or mid-DONE: the operation is discarded; the next cycle is IDLE with reset values, and no out_valid pulse is produced.
- Counter: loads WIDTH on entering BUSY, decrements each BUSY cycle, and BUSY exits when the counter reaches 1→0. The counter never wraps.
- Throughput: single-cycle ops achieve at best 1 op per 2 cycles (accept, then DONE/handshake).

Decomposition:
- Shared constants header: the op encodings (ADD, SUB, OR, AND, XOR, SLT, MULU, DIVU) and the FSM state encodings. Extend the existing ALU op defines; ADD/OR/SUB keep their values widened to 3 bits.
- One sub-module, seq_alu_muldiv: the iterative mul/div datapath.
  - Inputs: start, op, a, b.
  - Outputs: lo, hi, done.
  - Internals: 2·WIDTH accumulator and counter.
- The top level keeps the handshake FSM, single-cycle ops and flag generation.

Test Plan:
- ADD 0x7FFFFFFF + 0x00000001 → alu_dc = 0x80000000, alu_ovf = 1, alu_zero = 0, out_valid exactly 1 cycle after accept.
- SUB 5 − 5 → alu_dc = 0, alu_zero = 1, alu_ovf = 0. Then SLT 0xFFFFFFFF vs 1 → alu_dc = 1.
- MULU 0xFFFFFFFF × 2 → alu_dc = 0xFFFFFFFE, alu_hi = 1, alu_ovf = 1, out_valid exactly 33 cycles after accept, in_ready = 0 throughout.
- DIVU 100 / 7 → alu_dc = 14, alu_hi = 2, alu_ovf = 0 at 33 cycles. DIVU 100 / 0 → alu_dc = 0xFFFFFFFF, alu_hi = 100, alu_ovf = 1 at 1 cycle.
- Backpressure: hold out_ready = 0 for 5 cycles after out_valid → alu_dc/alu_hi/flags unchanged and in_ready = 0. Assert out_ready → IDLE next cycle, new op accepted.
- Assert rst for 1 cycle at BUSY cycle 10 of a MULU → out_valid never rises for that op, in_ready = 1 the cycle after reset, all outputs 0. A follow-up ADD 2 + 3 → 5.
